// File: rtl/pc_gen_ras_if.sv
// Fetch-address generator bus: control requests in, fetch PC and RAS status out.
interface pc_gen_ras_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_overflow;

  modport master (
    output stall, redirect_valid, redirect_pc, trap, call, ret,
    input  pc, ras_top, ras_count, ras_overflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, trap, call, ret,
    output pc, ras_top, ras_count, ras_overflow
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch PC register with trap/redirect/stall priority and a circular
// return-address stack. The stack pointer addresses the next free slot;
// the top entry lives at sp-1. When full, a push overwrites the slot at sp,
// which is the oldest entry.
module pc_gen_ras #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0080,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  pc_gen_ras_if.slave bus
);
  localparam int SPW = $clog2(RAS_DEPTH);
  localparam int CW  = SPW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [XLEN-1:0] stack_q [RAS_DEPTH];
  logic [XLEN-1:0] stack_d [RAS_DEPTH];

  logic            advance;
  logic            ras_op;
  logic            ras_empty;
  logic            ras_full;
  logic [SPW-1:0]  top_idx;
  logic [XLEN-1:0] top_val;
  logic [XLEN-1:0] pc_inc;

  assign advance   = bus.trap | bus.redirect_valid | ~bus.stall;
  assign ras_op    = advance & ~bus.trap;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));
  assign top_idx   = sp_q - SPW'(1);
  assign top_val   = ras_empty ? '0 : stack_q[top_idx];
  assign pc_inc    = pc_q + XLEN'(INC);

  // Next-PC selection, first match wins.
  always_comb begin
    pc_d = pc_inc;
    if (bus.trap)                        pc_d = TRAP_VEC;
    else if (bus.redirect_valid)         pc_d = bus.redirect_pc;
    else if (bus.stall)                  pc_d = pc_q;
    else if (bus.ret && !ras_empty)      pc_d = top_val;
  end

  // Return-address stack update: replace-top, push or pop.
  always_comb begin
    sp_d       = sp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    stack_d    = stack_q;
    if (ras_op) begin
      if (bus.call && bus.ret && !ras_empty) begin
        stack_d[top_idx] = pc_inc;
      end else if (bus.call) begin
        stack_d[sp_q] = pc_inc;
        sp_d          = sp_q + SPW'(1);
        if (ras_full) overflow_d = 1'b1;
        else          count_d    = count_q + CW'(1);
      end else if (bus.ret && !ras_empty) begin
        sp_d    = top_idx;
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      sp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stack_q    <= stack_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.ras_top      = top_val;
  assign bus.ras_count    = count_q;
  assign bus.ras_overflow = overflow_q;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: a queue-based reference model checked every cycle,
// plus literal expectations along a directed scenario.
module tb_pc_gen_ras;
  localparam int          XLEN = 32;
  localparam int          D    = 4;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0080;
  localparam int          INC  = 4;

  logic clk;
  logic reset;

  pc_gen_ras_if #(.XLEN(XLEN), .RAS_DEPTH(D)) bus ();

  pc_gen_ras #(
    .XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV), .INC(INC), .RAS_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the stack is a queue with the top at the back.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf;
  bit          m_valid = 0;

  always @(posedge clk) begin
    int          cnt;
    logic [31:0] top, npc, seq;
    if (reset) begin
      m_pc  = RV;
      m_stk.delete();
      m_ovf = 1'b0;
    end else begin
      cnt = m_stk.size();
      top = (cnt != 0) ? m_stk[cnt-1] : 32'h0;
      seq = m_pc + 32'(INC);
      if (bus.trap)                  npc = TV;
      else if (bus.redirect_valid)   npc = bus.redirect_pc;
      else if (bus.stall)            npc = m_pc;
      else if (bus.ret && cnt != 0)  npc = top;
      else                           npc = seq;
      if (!bus.trap && (bus.redirect_valid || !bus.stall)) begin
        if (bus.call && bus.ret && cnt != 0) begin
          m_stk[cnt-1] = seq;
        end else if (bus.call) begin
          if (cnt == D) begin
            m_stk.delete(0);
            m_ovf = 1'b1;
          end
          m_stk.push_back(seq);
        end else if (bus.ret && cnt != 0) begin
          m_stk.delete(cnt-1);
        end
      end
      m_pc = npc;
    end
    m_valid = 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int cnt;
    if (m_valid) begin
      cnt = m_stk.size();
      chk("model_pc", bus.pc, m_pc);
      chk("model_count", 32'(bus.ras_count), 32'(cnt));
      chk("model_top", bus.ras_top, (cnt != 0) ? m_stk[cnt-1] : 32'h0);
      chk("model_ovf", 32'(bus.ras_overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic tr, input logic ca, input logic re);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.trap           = tr;
    bus.call           = ca;
    bus.ret            = re;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic lit(input string tag, input logic [31:0] pc, input int cnt,
                     input logic [31:0] top, input logic ovf);
    chk({tag, "_pc"}, bus.pc, pc);
    chk({tag, "_count"}, 32'(bus.ras_count), 32'(cnt));
    chk({tag, "_top"}, bus.ras_top, top);
    chk({tag, "_ovf"}, 32'(bus.ras_overflow), 32'(ovf));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) tick();
    lit("reset", 32'h0, 0, 32'h0, 0);
    reset = 1'b0;

    // Free-run
    tick(); lit("run4", 32'h4, 0, 32'h0, 0);
    tick(); lit("run8", 32'h8, 0, 32'h0, 0);

    // Stall hold, release, redirect overriding stall
    drive(1, 0, 32'h0, 0, 0, 0);
    tick(); tick(); lit("stall", 32'h8, 0, 32'h0, 0);
    idle(); tick(); lit("release", 32'hC, 0, 32'h0, 0);
    drive(1, 1, 32'h40, 0, 0, 0);
    tick(); lit("stall_redir", 32'h40, 0, 32'h0, 0);

    // Call with redirect, then return
    drive(0, 1, 32'h10, 0, 0, 0); tick();
    drive(0, 1, 32'h100, 0, 1, 0);
    tick(); lit("call_redir", 32'h100, 1, 32'h14, 0);
    idle(); tick();
    drive(0, 0, 32'h0, 0, 0, 1);
    tick(); lit("ret1", 32'h14, 0, 32'h0, 0);

    // Five nested calls overflow a depth-4 stack
    drive(0, 1, 32'h0, 0, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 32'(i) << 8, 0, 1, 0);
      tick();
    end
    lit("nest", 32'h500, 4, 32'h404, 1);
    drive(0, 0, 32'h0, 0, 0, 1);
    tick(); chk("ret_a", bus.pc, 32'h404);
    tick(); chk("ret_b", bus.pc, 32'h304);
    tick(); chk("ret_c", bus.pc, 32'h204);
    tick(); lit("ret_d", 32'h104, 0, 32'h0, 1);
    tick(); lit("ret_empty", 32'h108, 0, 32'h0, 1);

    // Trap ignores stall and call; RAS untouched
    drive(0, 0, 32'h0, 0, 1, 0);
    tick(); lit("push", 32'h10C, 1, 32'h10C, 1);
    drive(1, 0, 32'h0, 1, 1, 0);
    tick(); lit("trap", 32'h80, 1, 32'h10C, 1);

    // Stalled ret is ignored
    drive(1, 0, 32'h0, 0, 0, 1);
    tick(); lit("stall_ret", 32'h80, 1, 32'h10C, 1);

    // Redirect with ret still pops
    drive(0, 1, 32'h200, 0, 0, 1);
    tick(); lit("redir_ret", 32'h200, 0, 32'h0, 1);

    // Reset mid-stream
    drive(0, 0, 32'h0, 0, 1, 0); tick();
    reset = 1'b1;
    tick(); lit("midreset", 32'h0, 0, 32'h0, 0);
    reset = 1'b0;
    idle();

    // Wrap-around
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    idle();
    tick(); chk("wrap", bus.pc, 32'h0);

    // call & ret together with two entries
    drive(0, 0, 32'h0, 0, 1, 0);
    tick(); tick(); lit("two", 32'h8, 2, 32'h8, 0);
    drive(0, 0, 32'h0, 0, 1, 1);
    tick(); lit("callret", 32'h8, 2, 32'hC, 0);
    drive(0, 0, 32'h0, 0, 0, 1);
    tick(); lit("after_cr", 32'hC, 1, 32'h4, 0);

    // call & ret on empty stack behaves as push
    tick(); lit("drain", 32'h4, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1, 1);
    tick(); lit("cr_empty", 32'h8, 1, 32'h8, 0);

    idle();
    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
